word_serializer: RTL and testbench
==================================

Name: word_serializer

Overview:
- Parametrised wide-to-narrow serializer: accepts one IN_W-bit word per input handshake and emits it as IN_W/OUT_W consecutive OUT_W-bit slices over a valid/ready output handshake.
- Generalises the fixed 32-to-8, free-running slice output to configurable widths and slice order, with back-pressure, a last-slice marker and a synchronous flush.
- Sits between a wide datapath register and a narrow output bus or port.

Parameters:
- IN_W, 32, input word width; must be an integer multiple of OUT_W.
- OUT_W, 8, output slice width.
- MSB_FIRST, 0:
  - 0 = first slice is bits [OUT_W-1:0], then ascending.
  - 1 = first slice is bits [IN_W-1:IN_W-OUT_W], then descending.
- Derived, not overridable:
  - N = IN_W/OUT_W, slices per word.
  - CW = clog2(N), minimum 1.

Ports:
- CLK_0  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of the word in flight.
- in_data  in  IN_W  word to serialize.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a word this cycle.
- out_data  out  OUT_W  current slice.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts the slice.
- out_last  out  1  current slice is slice N-1 of its word.
- slice_idx  out  CW  index (0..N-1) of the current slice in emission order.

Behaviour:
- Elaboration: if IN_W % OUT_W != 0 or N < 2, raise an elaboration error.
- States: IDLE (no word held) and SEND (word held in shift register, out_valid=1).
- Reset (RST=1, asynchronous, no wait for clock):
  - State goes to IDLE.
  - out_valid=0, out_last=0, slice_idx=0, out_data=0, shift register=0.
  - A word in flight is discarded.
- in_ready is combinational: (state==IDLE) || (state==SEND && out_last && out_ready).
- Input accept = in_valid && in_ready.
  - Loads in_data into the shift register and sets slice_idx=0.
  - State becomes SEND on the next cycle.
  - Latency: word accepted on edge k; first slice valid after edge k, so out_valid=1 in cycle k+1.
- Output accept = out_valid && out_ready.
  - Not last: shift by OUT_W toward the output end; slice_idx+1.
  - Last: go to IDLE, or if an input accept occurs the same cycle, reload directly and stay in SEND. This gives back-to-back words with no bubble: 1 slice per cycle sustained.
- Stall: while out_valid && !out_ready, out_data, out_last and slice_idx hold stable and in_ready=0.
- Slice order:
  - out_data is the register's bottom OUT_W bits when MSB_FIRST=0, top OUT_W bits when MSB_FIRST=1.
  - Slices are registered, not muxed from the live in_data; changing in_data after accept has no effect.
- out_last = (slice_idx == N-1) && out_valid.
- flush=1 at an edge:
  - State goes to IDLE, out_valid=0, slice_idx=0.
  - Flush has priority over any simultaneous input or output accept; the word offered that cycle is not taken.
  - in_ready is forced to 0 while flush=1.
- in_valid while in SEND and not on the last accepted slice: in_ready=0; the upstream word is held off, nothing is dropped.
- slice_idx is never greater than N-1 and wraps only by reload to 0.
- No combinational path from in_data to any output; out_data depends only on registers.

Test Plan:
- Default params, in_data=32'hA1B2C3D4, single accept, out_ready=1 constantly -> out_data D4,C3,B2,A1 on 4 consecutive cycles, starting the cycle after accept; slice_idx 0..3; out_last only on A1; then out_valid=0.
- MSB_FIRST=1, IN_W=24, OUT_W=8, word 24'h123456 -> slices 12,34,56; out_last on 56.
- Back-to-back: words 32'h03020100 and 32'h07060504 offered consecutively, out_ready=1 -> 8 contiguous slices 00..07 with no gap; in_ready=1 exactly in the last-slice cycle of the first word.
- Back-pressure: out_ready low for 3 cycles while slice C3 is presented -> C3 and slice_idx=1 held stable, in_ready=0; the sequence resumes with B2 when out_ready rises.
- Flush at slice_idx=2 with in_valid=1 the same cycle -> next cycle out_valid=0 and the offered word is not accepted; it is accepted the following cycle and its slice 0 is emitted.
- RST pulsed asynchronously mid-word, between clock edges -> out_valid, out_last and slice_idx go to 0 immediately; after release, in_ready=1 and a new word serializes from slice 0.

Source files
------------

// File: rtl/word_serializer.sv
// Wide-to-narrow serializer: one IN_W-bit word in, IN_W/OUT_W OUT_W-bit slices out,
// valid/ready on both sides, last-slice marker and synchronous flush.
module word_serializer #(
  parameter int unsigned IN_W      = 32,
  parameter int unsigned OUT_W     = 8,
  parameter bit          MSB_FIRST = 1'b0,
  localparam int unsigned N        = IN_W / OUT_W,
  localparam int unsigned CW       = (N > 2) ? $clog2(N) : 1
) (
  input  logic             CLK_0,
  input  logic             RST,
  input  logic             flush,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CW-1:0]    slice_idx
);

  if ((IN_W % OUT_W) != 0 || N < 2) begin : g_bad_params
    $error("word_serializer: IN_W must be a multiple of OUT_W with at least 2 slices");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state;
  logic [IN_W-1:0]   shreg;
  logic [IN_W-1:0]   shreg_next_slice;
  logic              in_accept;
  logic              out_accept;

  // Presented slice and advance direction both come from the held register only.
  if (MSB_FIRST) begin : g_msb
    assign out_data         = shreg[IN_W-1 -: OUT_W];
    assign shreg_next_slice = shreg << OUT_W;
  end else begin : g_lsb
    assign out_data         = shreg[OUT_W-1:0];
    assign shreg_next_slice = shreg >> OUT_W;
  end

  // A new word can land while idle, or in the same cycle the last slice leaves.
  assign in_ready   = !flush && ((state == IDLE) || (state == SEND && out_last && out_ready));
  assign in_accept  = in_valid && in_ready;
  assign out_accept = out_valid && out_ready;

  always_ff @(posedge CLK_0 or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      shreg     <= '0;
      slice_idx <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      slice_idx <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (in_accept) begin
      state     <= SEND;
      shreg     <= in_data;
      slice_idx <= '0;
      out_valid <= 1'b1;
      out_last  <= 1'b0;
    end else if (out_accept) begin
      if (out_last) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        shreg     <= shreg_next_slice;
        slice_idx <= slice_idx + CW'(1);
        out_last  <= (slice_idx == CW'(N - 2));
      end
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: default LSB-first 32->8 instance plus a 24->8 MSB-first instance.
module tb_word_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          total = 0;
  int          bad   = 0;

  // default instance signals
  logic        flush = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic [1:0]  slice_idx;

  // MSB-first 24->8 instance signals
  logic        m_flush = 1'b0;
  logic [23:0] m_in_data = '0;
  logic        m_in_valid = 1'b0;
  logic        m_in_ready;
  logic [7:0]  m_out_data;
  logic        m_out_valid;
  logic        m_out_ready = 1'b0;
  logic        m_out_last;
  logic [1:0]  m_slice_idx;

  always #5 clk = ~clk;

  word_serializer u_dut (
    .CLK_0(clk), .RST(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .slice_idx(slice_idx)
  );

  word_serializer #(.IN_W(24), .OUT_W(8), .MSB_FIRST(1'b1)) u_msb (
    .CLK_0(clk), .RST(rst), .flush(m_flush),
    .in_data(m_in_data), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .out_data(m_out_data), .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_last(m_out_last), .slice_idx(m_slice_idx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  logic [7:0] e1 [4];
  logic [7:0] e3 [3];

  initial begin
    e1[0] = 8'hD4; e1[1] = 8'hC3; e1[2] = 8'hB2; e1[3] = 8'hA1;
    e3[0] = 8'h12; e3[1] = 8'h34; e3[2] = 8'h56;

    // reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    chk("rst_idx",   32'(slice_idx), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_rdy",   32'(in_ready),  32'd1);
    chk("m_rst_rdy", 32'(m_in_ready), 32'd1);

    // single word, LSB first
    @(negedge clk);
    in_data = 32'hA1B2C3D4; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("t1_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_data = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_data",  32'(out_data),  32'(e1[i]));
      chk("t1_idx",   32'(slice_idx), 32'(i));
      chk("t1_last",  32'(out_last),  32'(i == 3));
      @(negedge clk);
    end
    #1 chk("t1_idle", 32'(out_valid), 32'd0);

    // MSB first, 24 -> 8
    @(negedge clk);
    m_in_data = 24'h123456; m_in_valid = 1'b1; m_out_ready = 1'b1;
    @(negedge clk);
    m_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_valid", 32'(m_out_valid), 32'd1);
      chk("t2_data",  32'(m_out_data),  32'(e3[i]));
      chk("t2_idx",   32'(m_slice_idx), 32'(i));
      chk("t2_last",  32'(m_out_last),  32'(i == 2));
      @(negedge clk);
    end
    #1 chk("t2_idle", 32'(m_out_valid), 32'd0);

    // back-to-back words, no bubble
    @(negedge clk);
    in_data = 32'h03020100; in_valid = 1'b1;
    #1 chk("t3_rdy0", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_data = 32'h07060504;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) in_valid = 1'b0;
      #1;
      chk("t3_valid", 32'(out_valid), 32'd1);
      chk("t3_data",  32'(out_data),  32'(i));
      chk("t3_idx",   32'(slice_idx), 32'(i % 4));
      chk("t3_last",  32'(out_last),  32'((i % 4) == 3));
      if (i < 4) chk("t3_rdy", 32'(in_ready), 32'(i == 3));
      @(negedge clk);
    end
    #1 chk("t3_idle", 32'(out_valid), 32'd0);

    // back-pressure on slice C3
    @(negedge clk);
    in_data = 32'hA1B2C3D4; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("t4_d4", 32'(out_data), 32'hD4);
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_hold_data", 32'(out_data),  32'hC3);
      chk("t4_hold_idx",  32'(slice_idx), 32'd1);
      chk("t4_hold_vld",  32'(out_valid), 32'd1);
      chk("t4_hold_rdy",  32'(in_ready),  32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("t4_c3", 32'(out_data), 32'hC3);
    @(negedge clk);
    #1 chk("t4_b2", 32'(out_data), 32'hB2);
    chk("t4_b2_idx", 32'(slice_idx), 32'd2);
    @(negedge clk);
    #1 chk("t4_a1", 32'(out_data), 32'hA1);
    chk("t4_a1_last", 32'(out_last), 32'd1);
    @(negedge clk);
    #1 chk("t4_idle", 32'(out_valid), 32'd0);

    // flush at slice 2 with a word offered in the same cycle
    @(negedge clk);
    in_data = 32'hA1B2C3D4; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("t5_idx2", 32'(slice_idx), 32'd2);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h55667788;
    #1 chk("t5_rdy_flush", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_idx",   32'(slice_idx), 32'd0);
    chk("t5_rdy",   32'(in_ready),  32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("t5_new_valid", 32'(out_valid), 32'd1);
    chk("t5_new_data",  32'(out_data),  32'h88);
    chk("t5_new_idx",   32'(slice_idx), 32'd0);
    repeat (4) @(negedge clk);
    #1 chk("t5_idle", 32'(out_valid), 32'd0);

    // asynchronous reset mid-word
    @(negedge clk);
    in_data = 32'hA1B2C3D4; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 chk("t6_pre_idx", 32'(slice_idx), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_last",  32'(out_last),  32'd0);
    chk("t6_idx",   32'(slice_idx), 32'd0);
    chk("t6_data",  32'(out_data),  32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    #1 chk("t6_rdy", 32'(in_ready), 32'd1);
    in_data = 32'hDEADBEEF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("t6_new_data", 32'(out_data),  32'hEF);
    chk("t6_new_idx",  32'(slice_idx), 32'd0);
    @(negedge clk);
    #1 chk("t6_new_data1", 32'(out_data), 32'hBE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
